// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl
//   Four-source interrupt controller for a Z80 bus, mode-2 style vectoring.
//   Peripheral request edges latch into a pending register. Any pending and
//   enabled request raises INT_L. The controller then places an even vector
//   on the data bus during the CPU acknowledge cycle (M1_L=0, IORQ_L=0) and
//   blocks further requests until software writes EOI.
//
//   I/O map, relative to BASE_PORT, decoded on addr_bus[7:0]:
//     +0  mask      R/W  bit i = 1 enables irq[i]
//     +1  pending   R    write 1 to clear
//     +2  vbase     R/W  vector = {vbase[7:3], id[1:0], 1'b0}
//     +3  EOI       W    data ignored; ends service
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_L        synchronous active-low reset
//   addr_bus     CPU address bus, only [7:0] decoded
//   data_out     CPU write data
//   data_in      read data / vector to the CPU, 8'hzz when not driving
//   M1_L         CPU M1 strobe, active low
//   IORQ_L       CPU I/O request, active low
//   RD_L         CPU read strobe, active low
//   WR_L         CPU write strobe, active low
//   irq          peripheral requests, rising edge sets pending
//   INT_L        interrupt request to the CPU, active low, registered
//   in_service   {valid, id[1:0]} of the interrupt currently in service
//   o_dbg_state  current FSM state (IDLE=0, REQ=1, ACK=2, SERVICE=3)
//   o_dbg_drive  1 while data_in is being driven
//
// Handshake: there is no valid/ready pair. A CPU write is accepted on the
// first cycle its strobes are seen (edge-detected, so a multi-cycle access
// acts once). Reads and the vector are combinational while the strobes are
// held. The acknowledge is taken on the first REQ cycle with M1_L=0 and
// IORQ_L=0; the cycle ends when IORQ_L returns high.

module z80_int_ctrl #(
  parameter logic [7:0] BASE_PORT = 8'h40
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_out,
  output logic [7:0]  data_in,
  input  logic        M1_L,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  input  logic [3:0]  irq,
  output logic        INT_L,
  output logic [2:0]  in_service,
  output logic [1:0]  o_dbg_state,
  output logic        o_dbg_drive
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_ACK     = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [3:0]  r_mask;
  logic [3:0]  r_pending;
  logic [7:0]  r_vbase;
  logic [3:0]  r_irq_q;
  logic        r_isv;
  logic [1:0]  r_id;
  logic        r_int_l;
  logic        r_io_wr_q;

  // Upper address byte is not part of the I/O decode.
  logic        w_unused_addr;
  assign w_unused_addr = ^addr_bus[15:8];

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  // Subtracting the base makes the decode correct for any BASE_PORT,
  // aligned or not; the window is hit when the offset is 0..3.
  logic [7:0]  w_off;
  logic        w_hit;
  assign w_off = addr_bus[7:0] - BASE_PORT;
  assign w_hit = (w_off[7:2] == 6'd0);

  // ---------------------------------------------------------------------
  // Bus cycle qualification
  // ---------------------------------------------------------------------
  logic w_io_wr;
  logic w_wr_pulse;
  logic w_io_rd;
  logic w_inta;

  assign w_io_wr    = ~IORQ_L & ~WR_L & M1_L;
  assign w_wr_pulse = w_io_wr & ~r_io_wr_q;
  assign w_io_rd    = ~IORQ_L & ~RD_L & M1_L & w_hit & (w_off[1:0] != 2'd3);
  assign w_inta     = ~M1_L & ~IORQ_L;

  logic w_wr_mask;
  logic w_wr_pend;
  logic w_wr_vbase;
  logic w_wr_eoi;

  assign w_wr_mask  = w_wr_pulse & w_hit & (w_off[1:0] == 2'd0);
  assign w_wr_pend  = w_wr_pulse & w_hit & (w_off[1:0] == 2'd1);
  assign w_wr_vbase = w_wr_pulse & w_hit & (w_off[1:0] == 2'd2);
  assign w_wr_eoi   = w_wr_pulse & w_hit & (w_off[1:0] == 2'd3);

  // ---------------------------------------------------------------------
  // Request edge detect and priority
  // ---------------------------------------------------------------------
  logic [3:0] w_rise;
  logic [3:0] w_active;
  logic [1:0] w_pri_id;

  assign w_rise   = irq & ~r_irq_q;
  assign w_active = r_pending & r_mask;

  // irq[0] has the highest priority.
  always_comb begin
    w_pri_id = 2'd0;
    if (w_active[0])      w_pri_id = 2'd0;
    else if (w_active[1]) w_pri_id = 2'd1;
    else if (w_active[2]) w_pri_id = 2'd2;
    else if (w_active[3]) w_pri_id = 2'd3;
  end

  // ---------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------
  logic w_take_ack;
  logic w_eoi_done;

  always_comb begin
    w_state_next = r_state;
    w_take_ack   = 1'b0;
    w_eoi_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_active) w_state_next = S_REQ;
      end
      S_REQ: begin
        // Request withdrawn (masked or cleared) before the CPU acknowledged.
        if (~|w_active) begin
          w_state_next = S_IDLE;
        end else if (w_inta) begin
          w_state_next = S_ACK;
          w_take_ack   = 1'b1;
        end
      end
      S_ACK: begin
        if (IORQ_L) w_state_next = S_SERVICE;
      end
      S_SERVICE: begin
        // EOI in any other state falls through and is ignored.
        if (w_wr_eoi) begin
          w_state_next = S_IDLE;
          w_eoi_done   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pending update
  // ---------------------------------------------------------------------
  // Clears come from W1C writes and from the acknowledge; a fresh edge on
  // the same bit in the same cycle is ORed in afterwards so it survives.
  logic [3:0] w_clr;
  logic [3:0] w_pending_next;

  always_comb begin
    w_clr = 4'h0;
    if (w_wr_pend)  w_clr = w_clr | data_out[3:0];
    if (w_take_ack) w_clr = w_clr | (4'b0001 << w_pri_id);
    w_pending_next = (r_pending & ~w_clr) | w_rise;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      r_state   <= S_IDLE;
      r_int_l   <= 1'b1;
      r_mask    <= 4'h0;
      r_pending <= 4'h0;
      r_vbase   <= 8'h00;
      r_isv     <= 1'b0;
      r_id      <= 2'd0;
      // Loading the current irq prevents a level already high at reset
      // release from being seen as a new edge.
      r_irq_q   <= irq;
      r_io_wr_q <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_int_l   <= (w_state_next != S_REQ);
      r_irq_q   <= irq;
      r_io_wr_q <= w_io_wr;
      r_pending <= w_pending_next;
      if (w_wr_mask)  r_mask  <= data_out[3:0];
      if (w_wr_vbase) r_vbase <= data_out;
      if (w_take_ack) begin
        r_isv <= 1'b1;
        r_id  <= w_pri_id;
      end else if (w_eoi_done) begin
        r_isv <= 1'b0;
        r_id  <= 2'd0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Data bus drive
  // ---------------------------------------------------------------------
  logic       w_drive;
  logic [7:0] w_rdata;

  always_comb begin
    w_drive = 1'b0;
    w_rdata = 8'h00;
    if ((r_state == S_ACK) && w_inta) begin
      w_drive = 1'b1;
      w_rdata = {r_vbase[7:3], r_id, 1'b0};
    end else if (w_io_rd) begin
      w_drive = 1'b1;
      case (w_off[1:0])
        2'd0:    w_rdata = {4'h0, r_mask};
        2'd1:    w_rdata = {4'h0, r_pending};
        2'd2:    w_rdata = r_vbase;
        default: w_rdata = 8'h00;
      endcase
    end
  end

  assign data_in     = w_drive ? w_rdata : 8'hzz;
  assign INT_L       = r_int_l;
  assign in_service  = {r_isv, r_id};
  assign o_dbg_state = r_state;
  assign o_dbg_drive = w_drive;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed testbench for z80_int_ctrl.
module tb_z80_int_ctrl;

  localparam logic [7:0] BASE = 8'h40;

  logic        clk;
  logic        rst_L;
  logic [15:0] addr_bus;
  logic [7:0]  data_out;
  wire  [7:0]  data_in;
  logic        M1_L;
  logic        IORQ_L;
  logic        RD_L;
  logic        WR_L;
  logic [3:0]  irq;
  logic        INT_L;
  logic [2:0]  in_service;
  logic [1:0]  dbg_state;
  logic        dbg_drive;

  int checks = 0;
  int errors = 0;

  z80_int_ctrl #(.BASE_PORT(BASE)) dut (
    .clk         (clk),
    .rst_L       (rst_L),
    .addr_bus    (addr_bus),
    .data_out    (data_out),
    .data_in     (data_in),
    .M1_L        (M1_L),
    .IORQ_L      (IORQ_L),
    .RD_L        (RD_L),
    .WR_L        (WR_L),
    .irq         (irq),
    .INT_L       (INT_L),
    .in_service  (in_service),
    .o_dbg_state (dbg_state),
    .o_dbg_drive (dbg_drive)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk);
    addr_bus = {8'h00, port};
    data_out = data;
    IORQ_L   = 1'b0;
    WR_L     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    IORQ_L   = 1'b1;
    WR_L     = 1'b1;
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] data,
                         output logic drv);
    @(negedge clk);
    addr_bus = {8'h00, port};
    IORQ_L   = 1'b0;
    RD_L     = 1'b0;
    #1;
    data = data_in;
    drv  = dbg_drive;
    #1;
    IORQ_L   = 1'b1;
    RD_L     = 1'b1;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    @(negedge clk);
    irq = v;
    @(negedge clk);
    irq = 4'h0;
  endtask

  task automatic wait_int(input int max_cycles, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(posedge clk);
      #1;
      if (INT_L === 1'b0) seen = 1'b1;
    end
  endtask

  task automatic ack_begin();
    @(negedge clk);
    M1_L   = 1'b0;
    IORQ_L = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic ack_end();
    @(negedge clk);
    M1_L   = 1'b1;
    IORQ_L = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] rd;
    logic       drv;
    rst_L = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_L = 1'b1;
    #1;
    checks++;
    if (INT_L !== 1'b1) begin
      errors++; $display("FAIL reset_int_l: got %b expected 1", INT_L);
    end
    checks++;
    if (in_service !== 3'b000) begin
      errors++; $display("FAIL reset_in_service: got %b expected 000", in_service);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    for (int p = 0; p < 3; p++) begin
      io_read(BASE + 8'(p), rd, drv);
      checks++;
      if ({drv, rd} !== {1'b1, 8'h00}) begin
        errors++;
        $display("FAIL reset_read_port%0d: drive=%b data=%h expected drive=1 data=00", p, drv, rd);
      end
    end
    io_read(BASE + 8'd3, rd, drv);
    checks++;
    if (drv !== 1'b0) begin
      errors++; $display("FAIL read_eoi_port_drive: got %b expected 0", drv);
    end
    io_read(8'h50, rd, drv);
    checks++;
    if (drv !== 1'b0) begin
      errors++; $display("FAIL read_unmapped_drive: got %b expected 0", drv);
    end
  endtask

  task automatic test_basic_ack();
    logic seen;
    io_write(BASE + 8'd0, 8'h06);
    io_write(BASE + 8'd2, 8'hA0);
    pulse_irq(4'b0100);
    wait_int(2, seen);
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL basic_int_low: INT_L=%b expected 0 within 2 cycles", INT_L);
    end
    ack_begin();
    checks++;
    if ({dbg_drive, data_in} !== {1'b1, 8'hA4}) begin
      errors++;
      $display("FAIL basic_vector: drive=%b data=%h expected drive=1 data=a4", dbg_drive, data_in);
    end
    checks++;
    if (in_service !== 3'b110) begin
      errors++; $display("FAIL basic_in_service: got %b expected 110", in_service);
    end
    ack_end();
    checks++;
    if ({INT_L, dbg_state} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL basic_after_ack: INT_L=%b state=%0d expected INT_L=1 state=3", INT_L, dbg_state);
    end
    io_write(BASE + 8'd3, 8'h00);
    #1;
    checks++;
    if ({in_service, dbg_state} !== {3'b000, 2'd0}) begin
      errors++;
      $display("FAIL basic_eoi: in_service=%b state=%0d expected 000/0", in_service, dbg_state);
    end
  endtask

  task automatic test_priority();
    logic seen;
    io_write(BASE + 8'd0, 8'h0F);
    pulse_irq(4'b0110);
    wait_int(3, seen);
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL prio_int_low: INT_L=%b expected 0", INT_L);
    end
    ack_begin();
    checks++;
    if ({dbg_drive, data_in, in_service} !== {1'b1, 8'hA2, 3'b101}) begin
      errors++;
      $display("FAIL prio_first: drive=%b data=%h isv=%b expected 1/a2/101", dbg_drive, data_in, in_service);
    end
    ack_end();
    checks++;
    if (INT_L !== 1'b1) begin
      errors++; $display("FAIL prio_service_int: got %b expected 1", INT_L);
    end
    io_write(BASE + 8'd3, 8'h00);
    wait_int(3, seen);
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL prio_second_int_low: INT_L=%b expected 0", INT_L);
    end
    ack_begin();
    checks++;
    if ({dbg_drive, data_in, in_service} !== {1'b1, 8'hA4, 3'b110}) begin
      errors++;
      $display("FAIL prio_second: drive=%b data=%h isv=%b expected 1/a4/110", dbg_drive, data_in, in_service);
    end
    ack_end();
    io_write(BASE + 8'd3, 8'h00);
  endtask

  task automatic test_masked();
    logic [7:0] rd;
    logic       drv;
    logic       went_low;
    io_write(BASE + 8'd0, 8'h00);
    pulse_irq(4'b1000);
    went_low = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (INT_L !== 1'b1) went_low = 1'b1;
    end
    checks++;
    if (went_low !== 1'b0) begin
      errors++; $display("FAIL masked_int: INT_L went low, expected stay 1");
    end
    io_read(BASE + 8'd1, rd, drv);
    checks++;
    if (rd !== 8'h08) begin
      errors++; $display("FAIL masked_pending: got %h expected 08", rd);
    end
    io_write(BASE + 8'd1, 8'h08);
    io_read(BASE + 8'd1, rd, drv);
    checks++;
    if (rd !== 8'h00) begin
      errors++; $display("FAIL w1c_pending: got %h expected 00", rd);
    end
  endtask

  task automatic test_set_wins();
    logic [7:0] rd;
    logic       drv;
    pulse_irq(4'b0100);
    // W1C of bit 2 on the same cycle as a new edge on irq[2]
    @(negedge clk);
    irq      = 4'b0100;
    addr_bus = {8'h00, BASE + 8'd1};
    data_out = 8'h04;
    IORQ_L   = 1'b0;
    WR_L     = 1'b0;
    @(negedge clk);
    irq      = 4'h0;
    @(negedge clk);
    IORQ_L   = 1'b1;
    WR_L     = 1'b1;
    io_read(BASE + 8'd1, rd, drv);
    checks++;
    if (rd !== 8'h04) begin
      errors++; $display("FAIL set_wins_pending: got %h expected 04", rd);
    end
    io_write(BASE + 8'd1, 8'h04);
    io_read(BASE + 8'd1, rd, drv);
    checks++;
    if (rd !== 8'h00) begin
      errors++; $display("FAIL set_wins_clear: got %h expected 00", rd);
    end
  endtask

  task automatic test_service_block();
    logic       seen;
    logic       went_low;
    logic [7:0] rd;
    logic       drv;
    io_write(BASE + 8'd0, 8'h0F);
    pulse_irq(4'b0010);
    wait_int(3, seen);
    ack_begin();
    checks++;
    if ({seen, data_in} !== {1'b1, 8'hA2}) begin
      errors++; $display("FAIL svc_first: seen=%b data=%h expected 1/a2", seen, data_in);
    end
    ack_end();
    pulse_irq(4'b0001);
    went_low = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (INT_L !== 1'b1) went_low = 1'b1;
    end
    checks++;
    if ({went_low, dbg_state} !== {1'b0, 2'd3}) begin
      errors++;
      $display("FAIL svc_no_nest: went_low=%b state=%0d expected 0/3", went_low, dbg_state);
    end
    io_write(BASE + 8'd3, 8'h00);
    wait_int(3, seen);
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL svc_after_eoi_int: INT_L=%b expected 0", INT_L);
    end
    ack_begin();
    checks++;
    if ({data_in, in_service} !== {8'hA0, 3'b100}) begin
      errors++; $display("FAIL svc_irq0_vector: data=%h isv=%b expected a0/100", data_in, in_service);
    end
    ack_end();
    io_write(BASE + 8'd3, 8'h00);
    // EOI with nothing in service must change nothing
    io_write(BASE + 8'd3, 8'h00);
    @(posedge clk);
    #1;
    checks++;
    if ({INT_L, in_service, dbg_state} !== {1'b1, 3'b000, 2'd0}) begin
      errors++;
      $display("FAIL eoi_idle: INT_L=%b isv=%b state=%0d expected 1/000/0", INT_L, in_service, dbg_state);
    end
    io_read(BASE + 8'd0, rd, drv);
    checks++;
    if (rd !== 8'h0F) begin
      errors++; $display("FAIL eoi_idle_mask: got %h expected 0f", rd);
    end
  endtask

  task automatic test_mask_withdraw();
    logic       seen;
    logic [7:0] rd;
    logic       drv;
    io_write(BASE + 8'd0, 8'h04);
    pulse_irq(4'b0100);
    wait_int(3, seen);
    io_write(BASE + 8'd0, 8'h00);
    #1;
    checks++;
    if ({seen, INT_L, dbg_state} !== {1'b1, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL withdraw: seen=%b INT_L=%b state=%0d expected 1/1/0", seen, INT_L, dbg_state);
    end
    io_read(BASE + 8'd1, rd, drv);
    checks++;
    if (rd !== 8'h04) begin
      errors++; $display("FAIL withdraw_pending: got %h expected 04", rd);
    end
    io_write(BASE + 8'd1, 8'h04);
  endtask

  task automatic test_reset_in_ack();
    logic       seen;
    logic [7:0] rd;
    logic       drv;
    io_write(BASE + 8'd0, 8'h0F);
    pulse_irq(4'b1000);
    wait_int(3, seen);
    ack_begin();
    checks++;
    if ({seen, data_in, in_service} !== {1'b1, 8'hA6, 3'b111}) begin
      errors++;
      $display("FAIL rst_ack_vector: seen=%b data=%h isv=%b expected 1/a6/111", seen, data_in, in_service);
    end
    @(negedge clk);
    rst_L = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({dbg_drive, INT_L, in_service, dbg_state} !== {1'b0, 1'b1, 3'b000, 2'd0}) begin
      errors++;
      $display("FAIL rst_in_ack: drive=%b INT_L=%b isv=%b state=%0d expected 0/1/000/0",
               dbg_drive, INT_L, in_service, dbg_state);
    end
    @(negedge clk);
    rst_L  = 1'b1;
    M1_L   = 1'b1;
    IORQ_L = 1'b1;
    io_read(BASE + 8'd0, rd, drv);
    checks++;
    if (rd !== 8'h00) begin
      errors++; $display("FAIL rst_mask_cleared: got %h expected 00", rd);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_L    = 1'b0;
    addr_bus = 16'h0000;
    data_out = 8'h00;
    M1_L     = 1'b1;
    IORQ_L   = 1'b1;
    RD_L     = 1'b1;
    WR_L     = 1'b1;
    irq      = 4'h0;

    test_reset();
    test_basic_ack();
    test_priority();
    test_masked();
    test_set_wins();
    test_service_block();
    test_mask_withdraw();
    test_reset_in_ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
